// File: rtl/id_register_file.sv
// General-purpose register bank with two combinational read ports, one write port,
// write-through bypass, and a handshaked debug dump engine that streams every register.
module id_register_file #(
  parameter int unsigned REGS    = 5,
  parameter int unsigned NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [REGS-1:0]    i_RS,
  input  logic [REGS-1:0]    i_RT,
  output logic [NB_DATA-1:0] o_RS_data,
  output logic [NB_DATA-1:0] o_RT_data,
  input  logic [REGS-1:0]    i_RD,
  input  logic               i_RegWrite,
  input  logic [NB_DATA-1:0] i_WriteData,
  input  logic               i_dbg_dump,
  input  logic               i_dbg_ready,
  output logic               o_dbg_valid,
  output logic [REGS-1:0]    o_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_dbg_busy,
  output logic               o_dbg_done
);

  localparam int unsigned    DEPTH    = 1 << REGS;
  localparam logic [REGS-1:0] LAST_IDX = REGS'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [NB_DATA-1:0] regs_q [DEPTH];
  state_t             state_q, state_d;
  logic [REGS-1:0]    idx_q, idx_d;
  logic               wr_en;

  // Register 0 is hardwired to zero: it is never written and reset to zero.
  assign wr_en = i_RegWrite && (i_RD != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_RD] <= i_WriteData;
    end
  end

  // Read ports and dump port see a same-cycle write through the bypass.
  assign o_RS_data  = (wr_en && (i_RD == i_RS))  ? i_WriteData : regs_q[i_RS];
  assign o_RT_data  = (wr_en && (i_RD == i_RT))  ? i_WriteData : regs_q[i_RT];
  assign o_dbg_data = (wr_en && (i_RD == idx_q)) ? i_WriteData : regs_q[idx_q];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (i_dbg_dump) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        // Valid is always high here, so ready alone marks a transfer.
        if (i_dbg_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + REGS'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake status decodes from the registered state only.
  assign o_dbg_valid = (state_q == SEND);
  assign o_dbg_busy  = (state_q == SEND) || (state_q == DONE);
  assign o_dbg_done  = (state_q == DONE);
  assign o_dbg_addr  = idx_q;

endmodule

// File: tb/tb_id_register_file.sv
// Directed self-checking bench for id_register_file: reads, writes, bypass and debug dump.
module tb_id_register_file;

  logic        i_clk;
  logic        i_reset;
  logic [4:0]  i_RS, i_RT, i_RD;
  logic [31:0] o_RS_data, o_RT_data;
  logic        i_RegWrite;
  logic [31:0] i_WriteData;
  logic        i_dbg_dump, i_dbg_ready;
  logic        o_dbg_valid;
  logic [4:0]  o_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        o_dbg_busy, o_dbg_done;

  int checks = 0;
  int errors = 0;

  id_register_file #(.REGS(5), .NB_DATA(32)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_RS        (i_RS),
    .i_RT        (i_RT),
    .o_RS_data   (o_RS_data),
    .o_RT_data   (o_RT_data),
    .i_RD        (i_RD),
    .i_RegWrite  (i_RegWrite),
    .i_WriteData (i_WriteData),
    .i_dbg_dump  (i_dbg_dump),
    .i_dbg_ready (i_dbg_ready),
    .o_dbg_valid (o_dbg_valid),
    .o_dbg_addr  (o_dbg_addr),
    .o_dbg_data  (o_dbg_data),
    .o_dbg_busy  (o_dbg_busy),
    .o_dbg_done  (o_dbg_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_RS = 5'd5; i_RT = 5'd31; i_RD = 5'd0;
    i_RegWrite = 1'b0; i_WriteData = 32'h0; i_dbg_dump = 1'b0; i_dbg_ready = 1'b0;
    #12;
    checks++; if (o_RS_data !== 32'h0) begin errors++; $display("FAIL reset_rs got %h exp 0", o_RS_data); end
    checks++; if (o_RT_data !== 32'h0) begin errors++; $display("FAIL reset_rt got %h exp 0", o_RT_data); end
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_dbg_valid); end
    checks++; if (o_dbg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_dbg_busy); end
    checks++; if (o_dbg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_dbg_done); end
    checks++; if (o_dbg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", o_dbg_addr); end
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg_data got %h exp 0", o_dbg_data); end
    @(negedge i_clk);
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    i_RD = 5'd31; i_WriteData = 32'h0040_0008; i_RegWrite = 1'b1;
    tick();
    i_RegWrite = 1'b0; i_WriteData = 32'h0; i_RS = 5'd31;
    #1;
    checks++; if (o_RS_data !== 32'h0040_0008) begin errors++; $display("FAIL jal_link got %h exp 00400008", o_RS_data); end
    i_RD = 5'd0; i_WriteData = 32'hFFFF_FFFF; i_RegWrite = 1'b1; i_RS = 5'd0; i_RT = 5'd0;
    #1;
    checks++; if (o_RS_data !== 32'h0) begin errors++; $display("FAIL r0_no_bypass got %h exp 0", o_RS_data); end
    tick();
    i_RegWrite = 1'b0;
    #1;
    checks++; if (o_RT_data !== 32'h0) begin errors++; $display("FAIL r0_write_dropped got %h exp 0", o_RT_data); end
  endtask

  task automatic test_bypass();
    i_RD = 5'd7; i_WriteData = 32'hDEAD_BEEF; i_RegWrite = 1'b0; i_RS = 5'd7; i_RT = 5'd7;
    #1;
    checks++; if (o_RS_data !== 32'h0) begin errors++; $display("FAIL nobyp_rs got %h exp 0", o_RS_data); end
    checks++; if (o_RT_data !== 32'h0) begin errors++; $display("FAIL nobyp_rt got %h exp 0", o_RT_data); end
    i_RegWrite = 1'b1;
    #1;
    checks++; if (o_RS_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp_rs got %h exp deadbeef", o_RS_data); end
    checks++; if (o_RT_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp_rt got %h exp deadbeef", o_RT_data); end
    tick();
    i_RegWrite = 1'b0; i_WriteData = 32'h1234_5678;
    #1;
    checks++; if (o_RS_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rs got %h exp deadbeef", o_RS_data); end
  endtask

  task automatic load_pattern();
    for (int i = 1; i < 32; i++) begin
      i_RD = 5'(i); i_WriteData = 32'(i * 32'h11); i_RegWrite = 1'b1;
      tick();
    end
    i_RegWrite = 1'b0; i_RD = 5'd0; i_WriteData = 32'h0;
  endtask

  task automatic start_dump();
    i_dbg_dump = 1'b1;
    tick();
    i_dbg_dump = 1'b0;
  endtask

  task automatic test_dump_full();
    load_pattern();
    i_dbg_ready = 1'b1;
    start_dump();
    for (int b = 0; b < 32; b++) begin
      i_dbg_dump = (b == 5);
      #1;
      checks++; if (o_dbg_valid !== 1'b1) begin errors++; $display("FAIL dump_valid beat %0d got %b exp 1", b, o_dbg_valid); end
      checks++; if (o_dbg_addr !== 5'(b)) begin errors++; $display("FAIL dump_addr beat %0d got %0d exp %0d", b, o_dbg_addr, b); end
      checks++; if (o_dbg_data !== 32'(b * 32'h11)) begin errors++; $display("FAIL dump_data beat %0d got %h exp %h", b, o_dbg_data, 32'(b * 32'h11)); end
      tick();
    end
    i_dbg_dump = 1'b0;
    checks++; if (o_dbg_done !== 1'b1) begin errors++; $display("FAIL dump_done got %b exp 1", o_dbg_done); end
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL dump_done_valid got %b exp 0", o_dbg_valid); end
    checks++; if (o_dbg_busy !== 1'b1) begin errors++; $display("FAIL dump_done_busy got %b exp 1", o_dbg_busy); end
    tick();
    checks++; if (o_dbg_done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", o_dbg_done); end
    checks++; if (o_dbg_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", o_dbg_busy); end
    tick();
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL no_restart got %b exp 0", o_dbg_valid); end
  endtask

  task automatic test_ready_toggle();
    int exp_addr;
    int cyc;
    logic [31:0] exp_data;
    exp_addr = 0;
    cyc = 0;
    i_dbg_ready = 1'b1;
    start_dump();
    while (exp_addr < 32 && cyc < 100) begin
      i_dbg_ready = !(cyc == 1 || cyc == 2);
      i_RegWrite  = (cyc == 1);
      i_RD        = 5'd1;
      i_WriteData = 32'hCAFE_0001;
      #1;
      exp_data = (exp_addr == 1 && cyc >= 1) ? 32'hCAFE_0001 : 32'(exp_addr * 32'h11);
      checks++; if (o_dbg_valid !== 1'b1) begin errors++; $display("FAIL hs_valid cyc %0d got %b exp 1", cyc, o_dbg_valid); end
      checks++; if (o_dbg_addr !== 5'(exp_addr)) begin errors++; $display("FAIL hs_addr cyc %0d got %0d exp %0d", cyc, o_dbg_addr, exp_addr); end
      checks++; if (o_dbg_data !== exp_data) begin errors++; $display("FAIL hs_data cyc %0d got %h exp %h", cyc, o_dbg_data, exp_data); end
      tick();
      i_RegWrite = 1'b0;
      if (i_dbg_ready) exp_addr++;
      cyc++;
    end
    checks++; if (cyc >= 100) begin errors++; $display("FAIL hs_timeout got %0d cycles exp < 100", cyc); end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL hs_cycles got %0d exp 34", cyc); end
    checks++; if (o_dbg_done !== 1'b1) begin errors++; $display("FAIL hs_done got %b exp 1", o_dbg_done); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_dump();
    i_dbg_ready = 1'b1;
    start_dump();
    for (int b = 0; b < 10; b++) tick();
    checks++; if (o_dbg_addr !== 5'd10) begin errors++; $display("FAIL pre_rst_addr got %0d exp 10", o_dbg_addr); end
    i_reset = 1'b1;
    i_RS = 5'd3; i_RT = 5'd31; i_RegWrite = 1'b0;
    #1;
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_dbg_valid); end
    checks++; if (o_dbg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_dbg_busy); end
    checks++; if (o_dbg_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", o_dbg_done); end
    checks++; if (o_RS_data !== 32'h0) begin errors++; $display("FAIL rst_rs got %h exp 0", o_RS_data); end
    checks++; if (o_RT_data !== 32'h0) begin errors++; $display("FAIL rst_rt got %h exp 0", o_RT_data); end
    @(negedge i_clk);
    i_reset = 1'b0;
    tick();
    start_dump();
    checks++; if (o_dbg_addr !== 5'd0) begin errors++; $display("FAIL restart_addr got %0d exp 0", o_dbg_addr); end
    checks++; if (o_dbg_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b exp 1", o_dbg_valid); end
    tick();
    checks++; if (o_dbg_addr !== 5'd1) begin errors++; $display("FAIL restart_addr1 got %0d exp 1", o_dbg_addr); end
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL restart_data1 got %h exp 0", o_dbg_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_dump_full();
    test_ready_toggle();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
